// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the hardwired CPU control sequencer:
// FSM states, opcode map, ALU operation codes and IR field positions.
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_T0,
      ST_T1,
      ST_T1W,
      ST_T2,
      ST_T3,
      ST_T4,
      ST_T5,
      ST_T6,
      ST_HALT
   } state_t;

   // Instruction families that share an execute sequence.
   typedef enum logic [2:0] {
      CLS_BINARY,
      CLS_MULDIV,
      CLS_UNARY,
      CLS_NOP,
      CLS_HALT,
      CLS_ILLEGAL
   } op_class_t;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_AND  = 5'b00010;
   localparam logic [4:0] OP_OR   = 5'b00011;
   localparam logic [4:0] OP_SHR  = 5'b00100;
   localparam logic [4:0] OP_SHL  = 5'b00101;
   localparam logic [4:0] OP_ROR  = 5'b00110;
   localparam logic [4:0] OP_ROL  = 5'b00111;
   localparam logic [4:0] OP_MUL  = 5'b01000;
   localparam logic [4:0] OP_DIV  = 5'b01001;
   localparam logic [4:0] OP_NEG  = 5'b01010;
   localparam logic [4:0] OP_NOT  = 5'b01011;
   localparam logic [4:0] OP_NOP  = 5'b01100;
   localparam logic [4:0] OP_HALT = 5'b01101;

   localparam logic [31:0] ALU_ADD   = 32'h0000_0001;
   localparam logic [31:0] ALU_SUB   = 32'h0000_0002;
   localparam logic [31:0] ALU_AND   = 32'h0000_0003;
   localparam logic [31:0] ALU_OR    = 32'h0000_0004;
   localparam logic [31:0] ALU_SHR   = 32'h0000_0005;
   localparam logic [31:0] ALU_SHL   = 32'h0000_0006;
   localparam logic [31:0] ALU_ROR   = 32'h0000_0007;
   localparam logic [31:0] ALU_ROL   = 32'h0000_0008;
   localparam logic [31:0] ALU_MUL   = 32'h0000_0009;
   localparam logic [31:0] ALU_DIV   = 32'h0000_000A;
   localparam logic [31:0] ALU_INCPC = 32'h0000_000F;
   localparam logic [31:0] ALU_NEG   = 32'h8000_0000;
   localparam logic [31:0] ALU_NOT   = 32'h9000_0000;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int RA_MSB  = 26;
   localparam int RA_LSB  = 23;
   localparam int RB_MSB  = 22;
   localparam int RB_LSB  = 19;
   localparam int RC_MSB  = 18;
   localparam int RC_LSB  = 15;

   function automatic op_class_t op_class(input logic [4:0] opcode);
      op_class_t cls;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CLS_BINARY;
         OP_MUL, OP_DIV:                 cls = CLS_MULDIV;
         OP_NEG, OP_NOT:                 cls = CLS_UNARY;
         OP_NOP:                         cls = CLS_NOP;
         OP_HALT:                        cls = CLS_HALT;
         default:                        cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

   function automatic logic [31:0] alu_code(input logic [4:0] opcode);
      logic [31:0] code;
      case (opcode)
         OP_ADD:  code = ALU_ADD;
         OP_SUB:  code = ALU_SUB;
         OP_AND:  code = ALU_AND;
         OP_OR:   code = ALU_OR;
         OP_SHR:  code = ALU_SHR;
         OP_SHL:  code = ALU_SHL;
         OP_ROR:  code = ALU_ROR;
         OP_ROL:  code = ALU_ROL;
         OP_MUL:  code = ALU_MUL;
         OP_DIV:  code = ALU_DIV;
         OP_NEG:  code = ALU_NEG;
         OP_NOT:  code = ALU_NOT;
         default: code = '0;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the 32-bit datapath (slave):
// IR and memory-ready come back from the datapath, every enable/select goes out.
interface control_sequencer_if;
   logic [31:0] ir;
   logic        mem_ready;
   logic [15:0] Rin;
   logic [15:0] Rout;
   logic        Pen;
   logic        Pselect;
   logic        MARen;
   logic        MDRen;
   logic        MDRselect;
   logic        Read;
   logic        IRen;
   logic        Yen;
   logic        Zen;
   logic        Zhighselect;
   logic        zlowselect;
   logic        HIen;
   logic        LOen;
   logic [31:0] alu_control;

   modport master (
      input  ir, mem_ready,
      output Rin, Rout, Pen, Pselect, MARen, MDRen, MDRselect, Read, IRen,
             Yen, Zen, Zhighselect, zlowselect, HIen, LOen, alu_control
   );

   modport slave (
      output ir, mem_ready,
      input  Rin, Rout, Pen, Pselect, MARen, MDRen, MDRselect, Read, IRen,
             Yen, Zen, Zhighselect, zlowselect, HIen, LOen, alu_control
   );
endinterface

// File: rtl/reg_decode4to16.sv
// One-hot decode of a 4-bit register index into R0..R15 enables; all-zero when
// not enabled so the register file sees no spurious strobe.
module reg_decode4to16 (
   input  logic [3:0]  sel,
   input  logic        en,
   output logic [15:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[sel] = 1'b1;
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: steps the datapath through fetch (T0..T2, with
// memory wait in T1W) and execute (T3..T6), one control step per clock.
module control_sequencer
   import cpu_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                clr,
   input  logic                run,
   control_sequencer_if.master bus,
   output logic                busy,
   output logic                done,
   output logic                halted,
   output logic                illegal
);

   state_t      state;
   state_t      next_state;
   state_t      boundary_state;
   logic [4:0]  opcode;
   logic [3:0]  ra;
   logic [3:0]  rb;
   logic [3:0]  rc;
   op_class_t   cls;
   logic        rin_en;
   logic        rout_en;
   logic [3:0]  rout_idx;
   logic [15:0] rin_onehot;
   logic [15:0] rout_onehot;
   logic        unused_ir_low;

   assign opcode        = bus.ir[OPC_MSB:OPC_LSB];
   assign ra            = bus.ir[RA_MSB:RA_LSB];
   assign rb            = bus.ir[RB_MSB:RB_LSB];
   assign rc            = bus.ir[RC_MSB:RC_LSB];
   assign unused_ir_low = ^bus.ir[RC_LSB-1:0];
   assign cls           = op_class(opcode);

   // run is only consulted at an instruction boundary.
   assign boundary_state = run ? ST_T0 : ST_IDLE;

   assign busy = (state != ST_IDLE) && (state != ST_HALT);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values and updates together.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state <= ST_IDLE;
      else      state <= next_state;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         halted  <= 1'b0;
         illegal <= 1'b0;
      end else if (state == ST_T2) begin
         if (cls == CLS_HALT) halted <= 1'b1;
         if (cls == CLS_ILLEGAL) begin
            halted  <= 1'b1;
            illegal <= 1'b1;
         end
      end
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case statements can leave it unassigned and infer a latch.
   always_comb begin
      next_state          = state;
      rin_en              = 1'b0;
      rout_en             = 1'b0;
      rout_idx            = rb;
      done                = 1'b0;
      bus.Pen             = 1'b0;
      bus.Pselect         = 1'b0;
      bus.MARen           = 1'b0;
      bus.MDRen           = 1'b0;
      bus.MDRselect       = 1'b0;
      bus.Read            = 1'b0;
      bus.IRen            = 1'b0;
      bus.Yen             = 1'b0;
      bus.Zen             = 1'b0;
      bus.Zhighselect     = 1'b0;
      bus.zlowselect      = 1'b0;
      bus.HIen            = 1'b0;
      bus.LOen            = 1'b0;
      bus.alu_control     = '0;

      case (state)
         ST_IDLE: begin
            if (run && !halted) next_state = ST_T0;
         end
         ST_T0: begin
            bus.Pselect     = 1'b1;
            bus.MARen       = 1'b1;
            bus.Zen         = 1'b1;
            bus.alu_control = ALU_INCPC;
            next_state      = ST_T1;
         end
         ST_T1: begin
            bus.zlowselect  = 1'b1;
            bus.Pen         = 1'b1;
            bus.Read        = 1'b1;
            bus.MDRen       = 1'b1;
            next_state      = bus.mem_ready ? ST_T2 : ST_T1W;
         end
         ST_T1W: begin
            bus.Read        = 1'b1;
            bus.MDRen       = 1'b1;
            if (bus.mem_ready) next_state = ST_T2;
         end
         ST_T2: begin
            bus.MDRselect   = 1'b1;
            bus.IRen        = 1'b1;
            case (cls)
               CLS_NOP: begin
                  done       = 1'b1;
                  next_state = boundary_state;
               end
               CLS_HALT, CLS_ILLEGAL: next_state = ST_HALT;
               default:               next_state = ST_T3;
            endcase
         end
         ST_T3: begin
            // Unary ops compute straight from the bus; binary ops latch Y first.
            rout_en  = 1'b1;
            rout_idx = rb;
            if (cls == CLS_UNARY) begin
               bus.alu_control = alu_code(opcode);
               bus.Zen         = 1'b1;
            end else begin
               bus.Yen         = 1'b1;
            end
            next_state = ST_T4;
         end
         ST_T4: begin
            if (cls == CLS_UNARY) begin
               bus.zlowselect = 1'b1;
               rin_en         = 1'b1;
               done           = 1'b1;
               next_state     = boundary_state;
            end else begin
               rout_en         = 1'b1;
               rout_idx        = rc;
               bus.alu_control = alu_code(opcode);
               bus.Zen         = 1'b1;
               next_state      = ST_T5;
            end
         end
         ST_T5: begin
            bus.zlowselect = 1'b1;
            if (cls == CLS_MULDIV) begin
               bus.LOen   = 1'b1;
               next_state = ST_T6;
            end else begin
               rin_en     = 1'b1;
               done       = 1'b1;
               next_state = boundary_state;
            end
         end
         ST_T6: begin
            bus.Zhighselect = 1'b1;
            bus.HIen        = 1'b1;
            done            = 1'b1;
            next_state      = boundary_state;
         end
         ST_HALT: begin
            next_state = ST_HALT;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   reg_decode4to16 u_rin_decode (
      .sel    (ra),
      .en     (rin_en),
      .onehot (rin_onehot)
   );

   reg_decode4to16 u_rout_decode (
      .sel    (rout_idx),
      .en     (rout_en),
      .onehot (rout_onehot)
   );

   assign bus.Rin  = rin_onehot;
   assign bus.Rout = rout_onehot;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues the expected control
// word for each upcoming cycle, a negedge monitor pops and compares.
module tb_control_sequencer;

   logic clk = 1'b0;
   logic clr;
   logic run;
   logic busy;
   logic done;
   logic halted;
   logic illegal;

   control_sequencer_if bus ();

   control_sequencer dut (
      .clk     (clk),
      .clr     (clr),
      .run     (run),
      .bus     (bus),
      .busy    (busy),
      .done    (done),
      .halted  (halted),
      .illegal (illegal)
   );

   always #5 clk = ~clk;

   // Control word order: Pen Pselect MARen MDRen MDRselect Read IRen Yen Zen Zhighselect zlowselect HIen LOen
   localparam logic [12:0] C_PEN   = 13'h1000;
   localparam logic [12:0] C_PSEL  = 13'h0800;
   localparam logic [12:0] C_MAREN = 13'h0400;
   localparam logic [12:0] C_MDREN = 13'h0200;
   localparam logic [12:0] C_MDRSL = 13'h0100;
   localparam logic [12:0] C_READ  = 13'h0080;
   localparam logic [12:0] C_IREN  = 13'h0040;
   localparam logic [12:0] C_YEN   = 13'h0020;
   localparam logic [12:0] C_ZEN   = 13'h0010;
   localparam logic [12:0] C_ZHI   = 13'h0008;
   localparam logic [12:0] C_ZLO   = 13'h0004;
   localparam logic [12:0] C_HIEN  = 13'h0002;
   localparam logic [12:0] C_LOEN  = 13'h0001;

   // Flag order: busy done halted illegal
   localparam logic [3:0] F_BUSY = 4'b1000;
   localparam logic [3:0] F_DONE = 4'b0100;
   localparam logic [3:0] F_HALT = 4'b0010;
   localparam logic [3:0] F_ILL  = 4'b0001;

   typedef struct {
      string       name;
      logic [15:0] rin;
      logic [15:0] rout;
      logic [12:0] ctl;
      logic [31:0] alu;
      logic [3:0]  flg;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [3:0] rc);
      return {op, ra, rb, rc, 15'h0};
   endfunction

   task automatic push_exp(input string name, input logic [15:0] rin, input logic [15:0] rout,
                           input logic [12:0] ctl, input logic [31:0] alu, input logic [3:0] flg);
      exp_t e;
      e.name = name;
      e.rin  = rin;
      e.rout = rout;
      e.ctl  = ctl;
      e.alu  = alu;
      e.flg  = flg;
      exp_q.push_back(e);
   endtask

   task automatic push_idle(input string name);
      push_exp(name, 16'h0, 16'h0, 13'h0, 32'h0, 4'b0000);
   endtask

   task automatic push_fetch(input string name, input int waits, input bit is_nop);
      push_exp({name, "_t0"}, 16'h0, 16'h0, C_PSEL | C_MAREN | C_ZEN, 32'h0000_000F, F_BUSY);
      push_exp({name, "_t1"}, 16'h0, 16'h0, C_ZLO | C_PEN | C_READ | C_MDREN, 32'h0, F_BUSY);
      for (int i = 0; i < waits; i++)
         push_exp({name, "_t1w"}, 16'h0, 16'h0, C_READ | C_MDREN, 32'h0, F_BUSY);
      push_exp({name, "_t2"}, 16'h0, 16'h0, C_MDRSL | C_IREN, 32'h0,
               is_nop ? (F_BUSY | F_DONE) : F_BUSY);
   endtask

   // Waits until the monitor has consumed every queued expectation; returns at posedge+1.
   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: %0d expectations left, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t        e;
      logic [12:0] act_ctl;
      logic [3:0]  act_flg;
      if (exp_q.size() != 0) begin
         e       = exp_q.pop_front();
         act_ctl = {bus.Pen, bus.Pselect, bus.MARen, bus.MDRen, bus.MDRselect, bus.Read,
                    bus.IRen, bus.Yen, bus.Zen, bus.Zhighselect, bus.zlowselect, bus.HIen,
                    bus.LOen};
         act_flg = {busy, done, halted, illegal};
         total++;
         if (bus.Rin !== e.rin || bus.Rout !== e.rout || act_ctl !== e.ctl ||
             bus.alu_control !== e.alu || act_flg !== e.flg) begin
            bad++;
            $display("FAIL %s: got Rin=%h Rout=%h ctl=%b alu=%h flags=%b; required Rin=%h Rout=%h ctl=%b alu=%h flags=%b",
                     e.name, bus.Rin, bus.Rout, act_ctl, bus.alu_control, act_flg,
                     e.rin, e.rout, e.ctl, e.alu, e.flg);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      clr           = 1'b0;
      run           = 1'b0;
      bus.ir        = 32'h0;
      bus.mem_ready = 1'b0;

      // Reset state, then idle with run low.
      push_idle("reset_a");
      push_idle("reset_b");
      drain();
      clr = 1'b1;
      push_idle("idle_run0_a");
      push_idle("idle_run0_b");
      drain();

      // ADD R3,R1,R2; run dropped mid-instruction must not truncate it.
      bus.ir        = mk_ir(5'b00000, 4'd3, 4'd1, 4'd2);
      bus.mem_ready = 1'b1;
      run           = 1'b1;
      push_idle("add_idle");
      push_fetch("add", 0, 1'b0);
      push_exp("add_t3", 16'h0000, 16'h0002, C_YEN, 32'h0, F_BUSY);
      push_exp("add_t4", 16'h0000, 16'h0004, C_ZEN, 32'h0000_0001, F_BUSY);
      push_exp("add_t5", 16'h0008, 16'h0000, C_ZLO, 32'h0, F_BUSY | F_DONE);
      push_idle("add_end");
      repeat (2) @(posedge clk);
      #1 run = 1'b0;
      drain();

      // NOT R0,R1: unary, 5 cycles.
      bus.ir = 32'h5808_0000;
      run    = 1'b1;
      push_idle("not_idle");
      push_fetch("not", 0, 1'b0);
      push_exp("not_t3", 16'h0000, 16'h0002, C_ZEN, 32'h9000_0000, F_BUSY);
      push_exp("not_t4", 16'h0001, 16'h0000, C_ZLO, 32'h0, F_BUSY | F_DONE);
      push_idle("not_end");
      repeat (2) @(posedge clk);
      #1 run = 1'b0;
      drain();

      // SUB R2,R2,R2 with memory slow by three cycles.
      bus.ir        = mk_ir(5'b00001, 4'd2, 4'd2, 4'd2);
      bus.mem_ready = 1'b0;
      run           = 1'b1;
      push_idle("sub_idle");
      push_fetch("sub", 3, 1'b0);
      push_exp("sub_t3", 16'h0000, 16'h0004, C_YEN, 32'h0, F_BUSY);
      push_exp("sub_t4", 16'h0000, 16'h0004, C_ZEN, 32'h0000_0002, F_BUSY);
      push_exp("sub_t5", 16'h0004, 16'h0000, C_ZLO, 32'h0, F_BUSY | F_DONE);
      push_idle("sub_end");
      repeat (2) @(posedge clk);
      #1 run = 1'b0;
      repeat (3) @(posedge clk);
      #1 bus.mem_ready = 1'b1;
      drain();

      // MUL R4,R5 (Ra=7 must never be written), back-to-back into a NOP.
      bus.ir = mk_ir(5'b01000, 4'd7, 4'd4, 4'd5);
      run    = 1'b1;
      push_idle("mul_idle");
      push_fetch("mul", 0, 1'b0);
      push_exp("mul_t3", 16'h0000, 16'h0010, C_YEN, 32'h0, F_BUSY);
      push_exp("mul_t4", 16'h0000, 16'h0020, C_ZEN, 32'h0000_0009, F_BUSY);
      push_exp("mul_t5", 16'h0000, 16'h0000, C_ZLO | C_LOEN, 32'h0, F_BUSY);
      push_exp("mul_t6", 16'h0000, 16'h0000, C_ZHI | C_HIEN, 32'h0, F_BUSY | F_DONE);
      push_fetch("nop", 0, 1'b1);
      push_idle("nop_end");
      repeat (8) @(posedge clk);
      #1;
      bus.ir = mk_ir(5'b01100, 4'd0, 4'd0, 4'd0);
      run    = 1'b0;
      drain();

      // ADD abandoned by a reset pulse inside T4.
      bus.ir = mk_ir(5'b00000, 4'd3, 4'd1, 4'd2);
      run    = 1'b1;
      push_idle("rst_idle");
      push_fetch("rst", 0, 1'b0);
      push_exp("rst_t3", 16'h0000, 16'h0002, C_YEN, 32'h0, F_BUSY);
      push_idle("rst_in_t4");
      push_idle("rst_after_a");
      push_idle("rst_after_b");
      push_idle("rst_after_c");
      repeat (5) @(posedge clk);
      #1;
      clr = 1'b0;
      run = 1'b0;
      #2 clr = 1'b1;
      drain();

      // Undefined opcode: sticky halt with run held high.
      bus.ir = mk_ir(5'b11111, 4'd1, 4'd2, 4'd3);
      run    = 1'b1;
      push_idle("ill_idle");
      push_fetch("ill", 0, 1'b0);
      for (int i = 0; i < 4; i++)
         push_exp("ill_halt", 16'h0, 16'h0, 13'h0, 32'h0, F_HALT | F_ILL);
      drain();
      clr = 1'b0;
      run = 1'b0;
      push_idle("ill_clr");
      push_idle("ill_after_clr");
      #2 clr = 1'b1;
      drain();

      // HALT opcode: halted without illegal.
      bus.ir = mk_ir(5'b01101, 4'd0, 4'd0, 4'd0);
      run    = 1'b1;
      push_idle("halt_idle");
      push_fetch("halt", 0, 1'b0);
      push_exp("halt_st_a", 16'h0, 16'h0, 13'h0, 32'h0, F_HALT);
      push_exp("halt_st_b", 16'h0, 16'h0, 13'h0, 32'h0, F_HALT);
      drain();
      clr = 1'b0;
      run = 1'b0;
      push_idle("halt_clr");
      #2 clr = 1'b1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

- Hardwired control unit that sequences the CPU datapath through instruction fetch and execute.
- Generates every register enable/select, memory read, and `alu_control` value the datapath consumes, one control step per clock.
- Waits on a memory-ready handshake during fetch.
- Sits between the top-level run control and the `datapath` block; replaces hand-driven bench sequencing.

## Interface
- No parameters; widths fixed by the 32-bit datapath.
- `clk`  in  1  system clock, all state on rising edge
- `clr`  in  1  asynchronous, active-low reset
- `run`  in  1  level; 1 = keep fetching/executing, 0 = stop at next instruction boundary
- `ir`  in  32  datapath IR contents; opcode `ir[31:27]`, Ra `ir[26:23]`, Rb `ir[22:19]`, Rc `ir[18:15]`
- `mem_ready`  in  1  memory data on `Mdatain` valid this cycle
- `Rin`  out  16  one-hot register enables R0..R15
- `Rout`  out  16  one-hot register bus selects R0..R15
- `Pen`, `Pselect`, `MARen`, `MDRen`, `MDRselect`, `Read`, `IRen`, `Yen`, `Zen`, `Zhighselect`, `zlowselect`, `HIen`, `LOen`  out  1 each  datapath controls
- `alu_control`  out  32  ALU operation code
- `busy`  out  1  instruction in progress
- `done`  out  1  one-cycle pulse on the last execute step of each instruction
- `halted`  out  1  sticky; HALT executed or illegal opcode
- `illegal`  out  1  sticky; set with `halted` on an undefined opcode

## Operation
- States: IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, HALT.
- Outputs are Moore-decoded from the state register plus live `ir` fields (IR is stable from T3 on).
- IDLE: all controls 0. Exits to T0 when `run`=1 and `halted`=0.
- T0: `Pselect`, `MARen`, `Zen`, `alu_control`=ALU_INCPC (32'h0000000F).
- T1: `zlowselect`, `Pen`, `Read`, `MDRen`.
  - `mem_ready`=1 -> T2; otherwise -> T1W.
- T1W: `Read`, `MDRen` only. Holds until `mem_ready`, then -> T2.
- T2: `MDRselect`, `IRen`.
- Binary ops (ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, MUL, DIV):
  - T3: `Rout[Rb]`, `Yen`.
  - T4: `Rout[Rc]`, `alu_control`=op code, `Zen`.
  - T5 (non-MUL/DIV): `zlowselect`, `Rin[Ra]`, `done`.
  - T5 (MUL/DIV): `zlowselect`, `LOen`.
  - T6 (MUL/DIV only): `Zhighselect`, `HIen`, `done`.
- Unary ops (NEG, NOT):
  - T3: `Rout[Rb]`, `alu_control`=op code, `Zen`.
  - T4: `zlowselect`, `Rin[Ra]`, `done`.
- NOP: T2 asserts `done` as well, then leaves the instruction.
- HALT opcode: T2 -> HALT, sets `halted`.
- Undefined opcode: T2 -> HALT, sets `halted` and `illegal`; no register is written.
- After the `done` step: -> T0 if `run`=1, else -> IDLE.
- HALT state: all controls 0. Exits only via `clr`.
- `busy`=1 in every state except IDLE and HALT.
- Ra=Rb or Ra=Rc is legal: the destination is written in the final step, after both operands have been read.

## Timing
- Reset (`clr` low, any state, mid-instruction included): state IDLE immediately.
  - All outputs 0: `Rin`, `Rout`, every 1-bit control, `alu_control`=32'h0, `busy`, `done`, `halted`, `illegal`.
  - A partially executed instruction is abandoned; no further enables are issued.
- Instruction cycles with zero memory wait:
  - NOP 3, unary 5, binary 6, MUL/DIV 7.
  - Each T1W cycle adds 1.
- `run` is sampled only in IDLE and on the `done` step. Dropping it mid-instruction does not truncate the instruction.
- At most one `Rout` bit, or one of `Pselect`/`MDRselect`/`zlowselect`/`Zhighselect`, is active in any cycle (bus exclusivity).
- `Rin` is one-hot or zero.
- `mem_ready` is ignored outside T1/T1W.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - state enum;
  - 5-bit opcode constants: ADD 00000 … ROL 00111, MUL 01000, DIV 01001, NEG 01010, NOT 01011, NOP 01100, HALT 01101;
  - 32-bit `alu_control` codes, including ALU_INCPC=32'h0000000F and ALU_NOT=32'h90000000;
  - IR field bit positions.
- Sub-module `reg_decode4to16` performs the one-hot decode of Ra/Rb/Rc into `Rin`/`Rout`.

## Test plan
- Reset mid-T4 of an ADD, `clr` pulsed low -> outputs all 0 within the same cycle; IDLE; no `Rin` pulse follows.
- `run`=1, `mem_ready` tied 1, `ir`=ADD R3,R1,R2 -> T0..T5 in 6 cycles:
  - `Rout`=0x0002 with `Yen`, then `Rout`=0x0004 with ADD code and `Zen`;
  - then `Rin`=0x0008 with `done`.
- NOT R0,R1 (`ir`=32'h5808_0000) -> T3 `Rout`=0x0002 with `alu_control`=32'h90000000; T4 `Rin`=0x0001; 5 cycles total.
- `mem_ready` held low 3 cycles after T1 -> exactly 3 T1W cycles with `Read`=`MDRen`=1; T2 follows the ready cycle.
- MUL R4,R5 -> T5 `LOen`, T6 `HIen` with `done`; `Rin` stays 0 throughout.
- Opcode 11111 -> `halted`=`illegal`=1 after T2; stays in HALT with `run`=1 until `clr`.
